// File: rtl/slsr_ctrl.sv
// Command sequencer for the slsr shift register: turns LOAD/SHL/SHR/ROL
// commands into per-cycle sl/sr/din pulses and returns the resulting Q.
module slsr_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CW-1:0]    cmd_count,
    output logic             sl,
    output logic             sr,
    output logic             din,
    input  logic [WIDTH-1:0] q_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_SHL  = 2'd1;
    localparam logic [1:0] OP_SHR  = 2'd2;
    localparam logic [1:0] OP_ROL  = 2'd3;

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    state_t           state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    eff_cnt;

    // LOAD always walks the full width; shifts clamp to the register width.
    always_comb begin
        eff_cnt = cmd_count;
        if (cmd_op == OP_LOAD || cmd_count > CNT_MAX)
            eff_cnt = CNT_MAX;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= OP_LOAD;
            data_q    <= '0;
            cnt       <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        data_q    <= cmd_data;
                        cnt       <= eff_cnt;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (eff_cnt == '0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (op_q == OP_LOAD)
                        data_q <= {data_q[WIDTH-2:0], 1'b0};
                    if (cnt == CW'(1)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Controls are combinational so the shift lands on the decrementing edge.
    always_comb begin
        sl  = 1'b0;
        sr  = 1'b0;
        din = 1'b0;
        if (state == RUN) begin
            unique case (op_q)
                OP_LOAD: begin
                    sl  = 1'b1;
                    din = data_q[WIDTH-1];
                end
                OP_SHL: begin
                    sl  = 1'b1;
                    din = data_q[0];
                end
                OP_SHR: begin
                    sr  = 1'b1;
                    din = data_q[0];
                end
                OP_ROL: begin
                    sl  = 1'b1;
                    din = q_in[WIDTH-1];
                end
            endcase
        end
    end

    assign rsp_data = q_in;

endmodule

// File: tb/tb_slsr_ctrl.sv
// Scoreboard bench for slsr_ctrl driving a behavioural slsr register,
// with directed and random commands against an arithmetic model.
module tb_slsr_ctrl;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CW-1:0]    cmd_count;
    logic             sl, sr, din;
    logic [WIDTH-1:0] q;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] data;
        int         n;
        int         nsl;
        int         nsr;
        bit         load;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_q;

    slsr_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .sl        (sl),
        .sr        (sr),
        .din       (din),
        .q_in      (q),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural slsr register.
    always @(posedge clk or posedge reset) begin
        if (reset)   q <= '0;
        else if (sl) q <= {q[WIDTH-2:0], din};
        else if (sr) q <= {din, q[WIDTH-1:1]};
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cyc %0d",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: invariants, shift accounting, scoreboard pop on response.
    int         acc_cyc = 0;
    int         nsl = 0, nsr = 0;
    logic [7:0] dseq = '0;
    bit         in_rsp = 0;
    logic [7:0] held = '0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            in_rsp = 0;
            nsl = 0;
            nsr = 0;
        end else begin
            check("sl_sr_excl", int'(sl & sr), 0);
            if (!busy) check("no_shift_idle", int'({sl, sr}), 0);
            if (sl) nsl++;
            if (sr) nsr++;
            if (sl || sr) dseq = {dseq[6:0], din};
            if (cmd_valid && cmd_ready) begin
                acc_cyc = cyc + 1;
                nsl = 0;
                nsr = 0;
                dseq = '0;
            end
            if (rsp_valid && !in_rsp) begin
                in_rsp = 1;
                held = rsp_data;
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_data", int'(rsp_data), int'(e.data));
                    check("latency", cyc - acc_cyc, e.n);
                    check("sl_cycles", nsl, e.nsl);
                    check("sr_cycles", nsr, e.nsr);
                    if (e.load) check("load_din_seq", int'(dseq), int'(e.data));
                end
            end else if (rsp_valid && in_rsp) begin
                check("rsp_stable", int'(rsp_data), int'(held));
                check("rsp_cmd_ready", int'(cmd_ready), 0);
            end
            if (!rsp_valid) in_rsp = 0;
        end
    end

    // Reference model: result of a command on the register, plain arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [7:0] d,
                                   input int c, input logic [7:0] qv);
        exp_t e;
        int   n, r, f, m;
        n = (op == 2'd0) ? 8 : ((c > 8) ? 8 : c);
        f = int'(d[0]);
        m = int'(qv);
        case (op)
            2'd0: r = int'(d);
            2'd1: r = (m << n) | (f != 0 ? ((1 << n) - 1) : 0);
            2'd2: r = (m >> n) | (f != 0 ? (255 & ~(255 >> n)) : 0);
            default: r = (m << n) | (m >> (8 - n));
        endcase
        e.data = 8'(r & 255);
        e.n    = n;
        e.nsl  = (op == 2'd2) ? 0 : n;
        e.nsr  = (op == 2'd2) ? n : 0;
        e.load = (op == 2'd0);
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [7:0] d,
                         input int c);
        exp_t e;
        int   t;
        t = 0;
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_timeout", 0, 1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_count = CW'(c);
        e = model(op, d, c, model_q);
        model_q = e.data;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = 8'($urandom);
        cmd_count = CW'($urandom);
    endtask

    task automatic finish_rsp(input int hold, input bit poke);
        int t;
        t = 0;
        while (!rsp_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rsp_valid) begin
            check("rsp_timeout", 0, 1);
            rsp_ready = 1'b1;
            return;
        end
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'($urandom);
                cmd_data  = 8'($urandom);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] d,
                        input int c, input int hold, input bit poke);
        rsp_ready = (hold == 0);
        issue(op, d, c);
        finish_rsp(hold, poke);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_q"}, int'(q), 0);
        check({tag, "_sl_sr"}, int'({sl, sr}), 0);
        check({tag, "_din"}, int'(din), 0);
        check({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        cmd_count = '0;
        rsp_ready = 1'b1;
        model_q   = '0;
        #1;
        check_reset_state("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        send(2'd0, 8'hA5, 0, 0, 0);
        send(2'd1, 8'h01, 3, 0, 0);
        send(2'd2, 8'h00, 2, 0, 0);
        send(2'd0, 8'hA5, 5, 0, 0);
        send(2'd3, 8'h00, 15, 0, 0);
        send(2'd3, 8'h00, 4, 0, 0);
        send(2'd1, 8'h01, 0, 5, 1);
        send(2'd2, 8'hFF, 9, 2, 1);
        send(2'd0, 8'h11, 0, 0, 0);

        rsp_ready = 1'b1;
        issue(2'd0, 8'h5B, 0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("mid_reset");
        sb.delete();
        model_q = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(2'd0, 8'h3C, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            send(2'($urandom), 8'($urandom), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
